// File: rtl/cell_color_pipe_pkg.sv
// rtl/cell_color_pipe_pkg.sv - shared mode encodings and default palette for the cell colour pipe
//
// Purpose : mode encodings, default palette colours and the reset-palette
//           lookup used by cell_color_pipe.
// Ports   : none (package)
package cell_color_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_FLASH  = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  localparam logic [23:0] SNAKE_RGB = 24'hF050A0;
  localparam logic [23:0] APPLE_RGB = 24'h00FF00;
  localparam logic [23:0] FIELD_RGB = 24'h000000;
  localparam logic [23:0] BACK_RGB  = 24'h206040;

  localparam int APPLE_TYPE = 5;

  // Reset value of palette entry idx; entry num_types is the background.
  function automatic logic [23:0] default_rgb(input int idx, input int num_types);
    if (idx == num_types) begin
      return BACK_RGB;
    end else if (idx >= 1 && idx <= 4) begin
      return SNAKE_RGB;
    end else if (idx == APPLE_TYPE) begin
      return APPLE_RGB;
    end else begin
      return FIELD_RGB;
    end
  endfunction

endpackage

// File: rtl/cell_color_pipe_blink_timer.sv
// rtl/cell_color_pipe_blink_timer.sv - frame-counting blink phase generator
//
// Purpose : counts frame_start pulses and toggles the blink phase every
//           BLINK_FRAMES frames. Runs regardless of display mode so the
//           phase stays continuous across mode changes.
// Ports   : i_clk         pixel clock
//           i_rst         asynchronous reset, active-high
//           i_frame_start one-cycle pulse at the start of each frame
//           o_blink_phase current blink half-period (0 after reset)
module cell_color_pipe_blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame_start,
  output logic o_blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap = (r_frame_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (i_frame_start) begin
      if (w_wrap) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_blink_phase = r_phase;

endmodule

// File: rtl/cell_color_pipe.sv
// rtl/cell_color_pipe.sv - two-stage programmable cell colouriser with blink/flash/blank
//
// Purpose : maps (grid_point_inside, grid_cell_type) to an RGB pixel through
//           a writable palette (NUM_TYPES cell entries + background), with
//           frame-synchronous blinking, flashing and blanking. Latency 2.
// Ports   : clk, rst (async, active-high)
//           pix_valid, grid_point_inside, grid_cell_type  pixel input
//           frame_start                                   frame pulse
//           mode                                          display mode
//           pal_we, pal_addr, pal_data                    palette write port
//           out_valid, red, green, blue                   registered pixel out
module cell_color_pipe
  import cell_color_pipe_pkg::*;
#(
  parameter int                   TYPE_W       = 3,
  parameter int                   NUM_TYPES    = 8,
  parameter int                   COLOR_W      = 8,
  parameter int                   BLINK_FRAMES = 16,
  parameter logic [NUM_TYPES-1:0] BLINK_MASK   = 8'h20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  input  logic                             grid_point_inside,
  input  logic [TYPE_W-1:0]                grid_cell_type,
  input  logic                             frame_start,
  input  logic [1:0]                       mode,
  input  logic                             pal_we,
  input  logic [$clog2(NUM_TYPES+1)-1:0]   pal_addr,
  input  logic [3*COLOR_W-1:0]             pal_data,
  output logic                             out_valid,
  output logic [COLOR_W-1:0]               red,
  output logic [COLOR_W-1:0]               green,
  output logic [COLOR_W-1:0]               blue
);

  localparam int IDX_W = $clog2(NUM_TYPES + 1);
  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_TYPES);

  // Palette: entries 0..NUM_TYPES-1 are cell colours, NUM_TYPES is background.
  logic [RGB_W-1:0] r_pal [0:NUM_TYPES];

  logic             w_blink_phase;
  logic [IDX_W-1:0] w_idx;
  logic             w_blink_flag;

  logic             r_s1_valid;
  logic [RGB_W-1:0] r_s1_rgb;
  logic             r_s1_blink;
  logic             r_s1_phase;

  mode_e            w_mode;
  logic [RGB_W-1:0] w_s2_rgb;

  cell_color_pipe_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .o_blink_phase (w_blink_phase)
  );

  // Palette write port. Reads elsewhere see the pre-edge contents, so a read
  // of the entry being written returns the old colour in the write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_TYPES; i++) begin
        r_pal[i] <= RGB_W'(default_rgb(i, NUM_TYPES));
      end
    end else if (pal_we && (pal_addr <= BG_IDX)) begin
      r_pal[pal_addr] <= pal_data;
    end
  end

  // Stage 1: palette lookup. Background index sits above every cell type.
  assign w_idx        = grid_point_inside ? IDX_W'(grid_cell_type) : BG_IDX;
  assign w_blink_flag = grid_point_inside & BLINK_MASK[grid_cell_type];

  // The phase is captured alongside the pixel so a frame_start in the same
  // cycle only affects later pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_rgb   <= '0;
      r_s1_blink <= 1'b0;
      r_s1_phase <= 1'b0;
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_rgb   <= r_pal[w_idx];
      r_s1_blink <= w_blink_flag;
      r_s1_phase <= w_blink_phase;
    end
  end

  // Stage 2: mode effects, with mode taken in this stage.
  assign w_mode = mode_e'(mode);

  always_comb begin
    w_s2_rgb = r_s1_rgb;
    case (w_mode)
      MODE_NORMAL: w_s2_rgb = r_s1_rgb;
      MODE_BLINK:  w_s2_rgb = (r_s1_blink && r_s1_phase) ? r_pal[0] : r_s1_rgb;
      MODE_FLASH:  w_s2_rgb = r_s1_phase ? ~r_s1_rgb : r_s1_rgb;
      MODE_BLANK:  w_s2_rgb = r_pal[NUM_TYPES];
      default:     w_s2_rgb = r_s1_rgb;
    endcase
  end

  // Output register: colour holds its last value while no pixel is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        {red, green, blue} <= w_s2_rgb;
      end
    end
  end

endmodule

// File: tb/tb_cell_color_pipe.sv
// tb/tb_cell_color_pipe.sv - scoreboard bench for cell_color_pipe
module tb_cell_color_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        grid_point_inside;
  logic [2:0]  grid_cell_type;
  logic        frame_start;
  logic [1:0]  mode;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic        out_valid;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  cell_color_pipe #(.BLINK_FRAMES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .pix_valid         (pix_valid),
    .grid_point_inside (grid_point_inside),
    .grid_cell_type    (grid_cell_type),
    .frame_start       (frame_start),
    .mode              (mode),
    .pal_we            (pal_we),
    .pal_addr          (pal_addr),
    .pal_data          (pal_data),
    .out_valid         (out_valid),
    .red               (red),
    .green             (green),
    .blue              (blue)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        v;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_id  = 0;

  // Reference model state.
  logic [23:0] m_pal [0:8];
  logic        m_phase;
  int          m_cnt;
  logic [1:0]  m_mode;

  task automatic model_reset();
    m_pal[0] = 24'h000000;
    for (int i = 1; i <= 4; i++) m_pal[i] = 24'hF050A0;
    m_pal[5] = 24'h00FF00;
    m_pal[6] = 24'h000000;
    m_pal[7] = 24'h000000;
    m_pal[8] = 24'h206040;
    m_phase  = 1'b0;
    m_cnt    = 0;
  endtask

  function automatic logic [23:0] model_color(input logic ins, input logic [2:0] t);
    logic [23:0] c;
    logic        bf;
    c  = ins ? m_pal[t] : m_pal[8];
    bf = ins && (t == 3'd5);
    case (m_mode)
      2'd0:    return c;
      2'd1:    return (bf && m_phase) ? m_pal[0] : c;
      2'd2:    return m_phase ? ~c : c;
      default: return m_pal[8];
    endcase
  endfunction

  // One clock of stimulus; expected result computed from pre-edge model state.
  task automatic step(input logic v, input logic ins, input logic [2:0] t,
                      input logic fs, input logic we, input logic [3:0] wa,
                      input logic [23:0] wd);
    exp_t e;
    pix_valid         = v;
    grid_point_inside = ins;
    grid_cell_type    = t;
    frame_start       = fs;
    pal_we            = we;
    pal_addr          = wa;
    pal_data          = wd;
    e.id  = 16'(n_id);
    e.v   = v;
    e.rgb = model_color(ins, t);
    n_id++;
    sbq.push_back(e);
    if (fs) begin
      if (m_cnt == 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    if (we && wa <= 4'd8) m_pal[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic ins, input logic [2:0] t);
    step(1'b1, ins, t, 1'b0, 1'b0, 4'd0, 24'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 24'h0);
  endtask

  task automatic set_mode(input logic [1:0] md);
    idle(2);
    mode   = md;
    m_mode = md;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    assert (out_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL %s out_valid: observed %b expected 0", tag, out_valid);
    end
    n_cmp++;
    assert ({red, green, blue} === 24'h0) else begin
      n_bad++;
      $error("FAIL %s rgb: observed %h expected 000000", tag, {red, green, blue});
    end
  endtask

  // Output lags the driven pixel by two edges; with one entry pushed per
  // cycle, the oldest entry is due once three are queued.
  always @(negedge clk) begin
    if (sbq.size() > 2) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      assert (out_valid === mon_e.v) else begin
        n_bad++;
        $error("FAIL pix%0d out_valid: observed %b expected %b", mon_e.id, out_valid, mon_e.v);
      end
      if (mon_e.v) begin
        n_cmp++;
        assert ({red, green, blue} === mon_e.rgb) else begin
          n_bad++;
          $error("FAIL pix%0d rgb: observed %h expected %h", mon_e.id, {red, green, blue}, mon_e.rgb);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    pix_valid = 0; grid_point_inside = 0; grid_cell_type = 0; frame_start = 0;
    mode = 2'd0; pal_we = 0; pal_addr = 0; pal_data = 0;
    m_mode = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic lookup: snake and background.
    pix(1'b1, 3'd1);
    pix(1'b0, 3'd1);
    idle(2);

    // Back-to-back burst of every type, then gapped pixels.
    for (int t = 0; t < 8; t++) pix(1'b1, 3'(t));
    pix(1'b1, 3'd2); idle(1); pix(1'b1, 3'd5); idle(2); pix(1'b0, 3'd0);
    idle(2);

    // Palette write with same-cycle read of entry 5, then ignored addr 9.
    step(1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 4'd5, 24'h123456);
    pix(1'b1, 3'd5);
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 4'd9, 24'hFFFFFF);
    for (int t = 0; t < 8; t++) pix(1'b1, 3'(t));
    pix(1'b0, 3'd0);
    // Restore apple colour for the blink test.
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd5, 24'h00FF00);

    // Blink mode across several blink periods; some frame_starts coincide
    // with valid pixels.
    set_mode(2'd1);
    for (int f = 0; f < 10; f++) begin
      step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 4'd0, 24'h0);
      pix(1'b1, 3'd5);
      pix(1'b1, 3'd1);
      pix(1'b0, 3'd5);
    end

    // Flash mode with phase 1, then blank mode.
    set_mode(2'd2);
    guard = 0;
    while (m_phase != 1'b1 && guard < 8) begin
      step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 24'h0);
      guard++;
    end
    pix(1'b1, 3'd1);
    pix(1'b1, 3'd5);
    pix(1'b0, 3'd3);
    set_mode(2'd3);
    pix(1'b1, 3'd1);
    pix(1'b1, 3'd5);
    pix(1'b0, 3'd0);

    // Async reset mid-burst after corrupting palette and phase state.
    set_mode(2'd0);
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 4'd5, 24'h123456);
    pix(1'b1, 3'd5);
    pix(1'b1, 3'd1);
    rst = 1'b1;
    sbq.delete();
    #1;
    check_reset_outputs("async_rst");
    pix_valid = 1'b0; pal_we = 1'b0; frame_start = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    pix(1'b1, 3'd5);
    set_mode(2'd2);
    pix(1'b1, 3'd1);
    pix(1'b0, 3'd0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
